// File: rtl/accumulator_dump_if.sv
// accumulator_dump_if
//   Valid/ready bus that carries captured epoch results from accumulator_dump
//   toward the tracking loop.
//   Signals:
//     dump_valid  head entry present (driven by master)
//     dump_ready  consumer accepts head (driven by slave)
//     dump_value  captured sum at head, ACC_WIDTH bits, two's complement
//     dump_count  number of samples in that sum, COUNT_WIDTH bits
//   Modports: master (producer side), slave (consumer side).
interface accumulator_dump_if #(
   parameter int unsigned ACC_WIDTH   = 20,
   parameter int unsigned COUNT_WIDTH = 15
);
   logic                   dump_valid;
   logic                   dump_ready;
   logic [ACC_WIDTH-1:0]   dump_value;
   logic [COUNT_WIDTH-1:0] dump_count;

   modport master (
      output dump_valid,
      output dump_value,
      output dump_count,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_value,
      input  dump_count,
      output dump_ready
   );
endinterface

// File: rtl/accumulator_dump.sv
// accumulator_dump
//   Holds the running state of a per-channel accumulator, drives its clear at
//   every code epoch, and captures each finished sum and sample count into a
//   small FIFO that drains over a valid/ready bus.
//   Ports:
//     clk              system clock
//     reset            synchronous, active-high reset
//     sample_valid     accumulator_out carries an updated sum this cycle
//     dump             code epoch: the current period ends this cycle
//     accumulator_out  combinational sum from the accumulator
//     accumulator_in   registered state fed back to the accumulator
//     clear            accumulator starts a new sum on the next valid sample
//     overflow         sticky: a capture was lost because the FIFO was full
//     overflow_clear   clears overflow (a simultaneous loss wins)
//     dump_bus         master side of the dump FIFO head (valid/ready/value/count)
module accumulator_dump #(
   parameter int unsigned ACC_WIDTH   = 20,
   parameter int unsigned COUNT_WIDTH = 15,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_valid,
   input  logic                 dump,
   input  logic [ACC_WIDTH-1:0] accumulator_out,
   output logic [ACC_WIDTH-1:0] accumulator_in,
   output logic                 clear,
   output logic                 overflow,
   input  logic                 overflow_clear,
   accumulator_dump_if.master   dump_bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   typedef logic [PTR_W:0] ptr_t;

   logic [ACC_WIDTH-1:0]   acc_q;
   logic                   clear_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   ovf_q;
   logic [ACC_WIDTH-1:0]   value_mem [DEPTH];
   logic [COUNT_WIDTH-1:0] count_mem [DEPTH];
   ptr_t                   wr_ptr_q;
   ptr_t                   rd_ptr_q;

   logic [COUNT_WIDTH-1:0] count_next;
   logic [ACC_WIDTH-1:0]   cap_value;
   logic [COUNT_WIDTH-1:0] cap_count;
   logic                   empty;
   logic                   full;
   logic                   pop;
   logic                   push;
   logic                   lost;

   // A sample taken while clear is set starts a fresh period at count 1.
   always_comb begin
      if (clear_q) begin
         count_next = COUNT_WIDTH'(1);
      end else if (&count_q) begin
         count_next = count_q;
      end else begin
         count_next = count_q + COUNT_WIDTH'(1);
      end
   end

   // Capture source: a sample in the dump cycle still belongs to the ending
   // period; with no sample since the last epoch the period is empty.
   always_comb begin
      cap_value = '0;
      cap_count = '0;
      if (sample_valid) begin
         cap_value = accumulator_out;
         cap_count = count_next;
      end else if (!clear_q) begin
         cap_value = acc_q;
         cap_count = count_q;
      end
   end

   // Extra pointer MSB distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop   = !empty && dump_bus.dump_ready;
   assign push  = dump && (!full || pop);
   assign lost  = dump && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         clear_q  <= 1'b1;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            value_mem[i] <= '0;
            count_mem[i] <= '0;
         end
      end else begin
         if (sample_valid) begin
            acc_q <= accumulator_out;
         end
         if (dump) begin
            clear_q <= 1'b1;
            count_q <= '0;
         end else if (sample_valid) begin
            clear_q <= 1'b0;
            count_q <= count_next;
         end
         if (push) begin
            value_mem[wr_ptr_q[PTR_W-1:0]] <= cap_value;
            count_mem[wr_ptr_q[PTR_W-1:0]] <= cap_count;
            wr_ptr_q                       <= wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ptr_t'(1);
         end
         if (lost) begin
            ovf_q <= 1'b1;
         end else if (overflow_clear) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign accumulator_in      = acc_q;
   assign clear               = clear_q;
   assign overflow            = ovf_q;
   assign dump_bus.dump_valid = !empty;
   assign dump_bus.dump_value = value_mem[rd_ptr_q[PTR_W-1:0]];
   assign dump_bus.dump_count = count_mem[rd_ptr_q[PTR_W-1:0]];
endmodule

// File: tb/tb_accumulator_dump.sv
// tb_accumulator_dump
//   Directed bench for accumulator_dump. A small accumulator stand-in feeds
//   accumulator_out from the DUT's own feedback; an abstract model (running
//   sum, sample count and a queue of captured periods) predicts every output
//   and is compared each cycle, with literal expectations pinning key points.
module tb_accumulator_dump;
   localparam int unsigned AW    = 20;
   localparam int unsigned CW    = 15;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] v;
      logic [CW-1:0] c;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          sample_valid;
   logic          dump;
   logic [AW-1:0] x;
   logic [AW-1:0] acc_out;
   logic [AW-1:0] acc_in;
   logic          clear;
   logic          overflow;
   logic          overflow_clear;

   accumulator_dump_if #(.ACC_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

   accumulator_dump #(.ACC_WIDTH(AW), .COUNT_WIDTH(CW), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .sample_valid    (sample_valid),
      .dump            (dump),
      .accumulator_out (acc_out),
      .accumulator_in  (acc_in),
      .clear           (clear),
      .overflow        (overflow),
      .overflow_clear  (overflow_clear),
      .dump_bus        (bus.master)
   );

   always #5 clk = ~clk;

   // Accumulator stand-in: adds the new sample to the fed-back state.
   assign acc_out = (clear ? '0 : acc_in) + x;

   int   errs   = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   logic [AW-1:0] m_sum;
   int            m_cnt;
   bit            m_clear;
   bit            m_ovf;
   ent_t          m_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      ent_t cap;
      bit   lost;
      if (reset) begin
         m_sum   = '0;
         m_cnt   = 0;
         m_clear = 1'b1;
         m_ovf   = 1'b0;
         m_q.delete();
         return;
      end
      if (sample_valid) begin
         if (m_clear) begin
            m_sum = x;
            m_cnt = 1;
         end else begin
            m_sum = m_sum + x;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
         end
      end
      cap = (sample_valid || !m_clear) ? {m_sum, CW'(m_cnt)} : '0;
      if (sample_valid) m_clear = 1'b0;
      if (m_q.size() != 0 && bus.dump_ready) void'(m_q.pop_front());
      lost = 1'b0;
      if (dump) begin
         if (m_q.size() < DEPTH) m_q.push_back(cap);
         else lost = 1'b1;
         m_clear = 1'b1;
         m_cnt   = 0;
      end
      if (lost) m_ovf = 1'b1;
      else if (overflow_clear) m_ovf = 1'b0;
   endtask

   task automatic step(input bit s, input logic [AW-1:0] xv, input bit d, input bit r,
                       input bit oc, input bit rs);
      sample_valid   = s;
      x              = xv;
      dump           = d;
      bus.dump_ready = r;
      overflow_clear = oc;
      reset          = rs;
      @(posedge clk);
      #1;
      model_update();
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("acc_in", 32'(acc_in), 32'(m_sum));
         check("clear", 32'(clear), 32'(m_clear));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("dump_valid", 32'(bus.dump_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            check("dump_value", 32'(bus.dump_value), 32'(m_q[0].v));
            check("dump_count", 32'(bus.dump_count), 32'(m_q[0].c));
         end
      end
   end

   initial begin
      logic [AW-1:0] exp_order [4];
      exp_order[0] = 20'd11;
      exp_order[1] = 20'd12;
      exp_order[2] = 20'd13;
      exp_order[3] = 20'd20;

      // 1) reset state, then five +3 samples with dump on the fifth
      step(0, '0, 0, 1, 0, 1);
      step(0, '0, 0, 1, 0, 1);
      chk_en = 1'b1;
      check("rst_acc_in", 32'(acc_in), 32'd0);
      check("rst_clear", 32'(clear), 32'd1);
      check("rst_valid", 32'(bus.dump_valid), 32'd0);
      check("rst_value", 32'(bus.dump_value), 32'd0);
      check("rst_count", 32'(bus.dump_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) step(1, 20'd3, 0, 1, 0, 0);
      step(1, 20'd3, 1, 1, 0, 0);
      check("t1_valid", 32'(bus.dump_valid), 32'd1);
      check("t1_value", 32'(bus.dump_value), 32'd15);
      check("t1_count", 32'(bus.dump_count), 32'd5);
      check("t1_clear", 32'(clear), 32'd1);
      step(0, '0, 0, 1, 0, 0);
      check("t1_clear_hold", 32'(clear), 32'd1);
      check("t1_popped", 32'(bus.dump_valid), 32'd0);

      // 2) three -2 samples, dump without a sample, then +1 restarts the sum
      for (int i = 0; i < 3; i++) step(1, 20'hFFFFE, 0, 1, 0, 0);
      step(0, '0, 1, 1, 0, 0);
      check("t2_value", 32'(bus.dump_value), 32'h000FFFFA);
      check("t2_count", 32'(bus.dump_count), 32'd3);
      step(1, 20'd1, 0, 1, 0, 0);
      check("t2_restart", 32'(acc_in), 32'd1);
      check("t2_clear", 32'(clear), 32'd0);

      // 3) two consecutive dumps with no samples between
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0);
      check("t3_first_value", 32'(bus.dump_value), 32'd1);
      check("t3_first_count", 32'(bus.dump_count), 32'd1);
      step(0, '0, 0, 1, 0, 0);
      check("t3_second_valid", 32'(bus.dump_valid), 32'd1);
      check("t3_second_value", 32'(bus.dump_value), 32'd0);
      check("t3_second_count", 32'(bus.dump_count), 32'd0);
      step(0, '0, 0, 1, 0, 0);
      check("t3_empty", 32'(bus.dump_valid), 32'd0);

      // 4) five dumps into a stalled FIFO, then dump+pop on full
      for (int i = 0; i < 5; i++) step(1, AW'(10 + i), 1, 0, 0, 0);
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_head", 32'(bus.dump_value), 32'd10);
      step(1, 20'd20, 1, 1, 0, 0);
      check("t4_ovf_unchanged", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("t4_order", 32'(bus.dump_value), 32'(exp_order[i]));
         check("t4_order_count", 32'(bus.dump_count), 32'd1);
         step(0, '0, 0, 1, 0, 0);
      end
      check("t4_drained", 32'(bus.dump_valid), 32'd0);

      // 5) overflow_clear collides with a lost dump
      step(0, '0, 0, 0, 1, 0);
      check("t5_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) step(1, AW'(30 + i), 1, 0, 0, 0);
      check("t5_full_no_ovf", 32'(overflow), 32'd0);
      step(1, 20'd40, 1, 0, 1, 0);
      check("t5_set_wins", 32'(overflow), 32'd1);
      check("t5_head", 32'(bus.dump_value), 32'd30);

      // 6) reset with three entries queued and a partial sum
      step(0, '0, 0, 1, 0, 0);
      step(1, 20'd5, 0, 0, 0, 0);
      step(1, 20'd6, 0, 0, 0, 0);
      check("t6_partial", 32'(acc_in), 32'd11);
      check("t6_queued", 32'(bus.dump_value), 32'd31);
      step(0, '0, 0, 0, 0, 1);
      check("t6_valid", 32'(bus.dump_valid), 32'd0);
      check("t6_acc_in", 32'(acc_in), 32'd0);
      check("t6_clear", 32'(clear), 32'd1);
      check("t6_overflow", 32'(overflow), 32'd0);
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 1, 0, 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
